tile_feeder: RTL and testbench

Upstream stage of the three-lane skew formatter. Buffers one 3×3 tile of signed `int_bits` values written element-serially, then streams the tile row by row onto three parallel lanes. It appends two zero-vector flush beats so the downstream skew registers (lane 1 delayed 1 cycle, lane 0 delayed 2 cycles) fully drain. Lane outputs connect directly to the formatter's `in2`/`in1`/`in0`.

---
 rtl/feeder_pkg.sv | 13 +
 rtl/tile_buffer.sv | 34 +++
 rtl/tile_feeder.sv | 109 ++++++++++
 tb/tb_tile_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state type, tile geometry constants and index helpers for tile_feeder
package feeder_pkg;
  typedef enum logic [1:0] {LOAD, FULL, STREAM, FLUSH} feeder_state_t;
  localparam int LANES = 3;
  localparam int TILE_ELEMS = 9;
  localparam int FLUSH_BEATS = LANES - 1;
  function automatic logic [1:0] elem_row(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction
  function automatic logic [1:0] elem_col(input logic [3:0] k);
    return 2'(k % 4'd3);
  endfunction
endpackage

// File: rtl/tile_buffer.sv
// tile_buffer: 3x3 register array with a single element write port and a whole-row read port
//   clk, reset  clock, asynchronous active-high clear of every element
//   we_i        write enable
//   widx_i      row-major element index 0..8
//   wdata_i     element value
//   ridx_i      row to read 0..2
//   row_o       row_o[c] = element at (ridx_i, c)
module tile_buffer
  import feeder_pkg::*;
#(
  parameter int int_bits = 13
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               we_i,
  input  logic [3:0]                         widx_i,
  input  logic [int_bits-1:0]                wdata_i,
  input  logic [1:0]                         ridx_i,
  output logic [LANES-1:0][int_bits-1:0]     row_o
);
  logic [int_bits-1:0] m_q [LANES][LANES];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < LANES; r++)
        for (int c = 0; c < LANES; c++)
          m_q[r][c] <= '0;
    end else if (we_i) begin
      m_q[elem_row(widx_i)][elem_col(widx_i)] <= wdata_i;
    end
  end
  always_comb
    for (int c = 0; c < LANES; c++)
      row_o[c] = m_q[ridx_i][c];
endmodule

// File: rtl/tile_feeder.sv
// tile_feeder: buffers one 3x3 tile written element-serially, then streams it row by row on three lanes plus two zero flush beats
//   clk, reset   clock, asynchronous active-high reset
//   wr_valid/wr_data/wr_ready  element write handshake, row-major order
//   start        request to stream the loaded tile (honoured only when full)
//   lane2/1/0    columns 0/1/2 of the current row, registered
//   lane_valid   lanes carry a stream or flush beat
//   full         tile loaded, waiting for start
//   done         one-cycle pulse after the last flush beat
module tile_feeder
  import feeder_pkg::*;
#(
  parameter int int_bits = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [int_bits-1:0] wr_data,
  output logic                wr_ready,
  input  logic                start,
  output logic [int_bits-1:0] lane2,
  output logic [int_bits-1:0] lane1,
  output logic [int_bits-1:0] lane0,
  output logic                lane_valid,
  output logic                full,
  output logic                done
);
  feeder_state_t state_q, state_d;
  logic [3:0] widx_q, widx_d;
  logic [1:0] ridx_q, ridx_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [LANES-1:0][int_bits-1:0] lanes_q, lanes_d, row;
  logic valid_q, valid_d, done_q, done_d, we;

  tile_buffer #(.int_bits(int_bits)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .widx_i  (widx_q),
    .wdata_i (wr_data),
    .ridx_i  (ridx_q),
    .row_o   (row)
  );

  assign wr_ready   = state_q == LOAD;
  assign full       = state_q == FULL;
  assign lane2      = lanes_q[0];
  assign lane1      = lanes_q[1];
  assign lane0      = lanes_q[2];
  assign lane_valid = valid_q;
  assign done       = done_q;

  // Lanes default to zero so flush beats and idle cycles need no explicit clearing.
  // FLUSH spends one extra cycle after its beats to drop lane_valid and raise done.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    fcnt_d  = fcnt_q;
    lanes_d = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      LOAD: if (wr_valid) begin
        we      = 1'b1;
        widx_d  = widx_q == 4'(TILE_ELEMS-1) ? 4'd0 : widx_q + 4'd1;
        state_d = widx_q == 4'(TILE_ELEMS-1) ? FULL : LOAD;
      end
      FULL: if (start) begin
        state_d = STREAM;
        ridx_d  = 2'd0;
      end
      STREAM: begin
        lanes_d = row;
        valid_d = 1'b1;
        ridx_d  = ridx_q == 2'(LANES-1) ? 2'd0 : ridx_q + 2'd1;
        state_d = ridx_q == 2'(LANES-1) ? FLUSH : STREAM;
        fcnt_d  = 2'd0;
      end
      FLUSH: begin
        valid_d = fcnt_q != 2'(FLUSH_BEATS);
        done_d  = fcnt_q == 2'(FLUSH_BEATS);
        fcnt_d  = fcnt_q == 2'(FLUSH_BEATS) ? 2'd0 : fcnt_q + 2'd1;
        state_d = fcnt_q == 2'(FLUSH_BEATS) ? LOAD : FLUSH;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      widx_q  <= '0;
      ridx_q  <= '0;
      fcnt_q  <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      fcnt_q  <= fcnt_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_tile_feeder.sv
// tb_tile_feeder: directed stimulus for tile_feeder with a tile/beat-queue reference model checked every cycle
module tb_tile_feeder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [12:0] wr_data = '0;
  logic        start = 1'b0;
  logic        wr_ready, lane_valid, full, done;
  logic [12:0] lane2, lane1, lane0;
  int errs = 0;
  int checks = 0;

  tile_feeder #(.int_bits(13)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .start      (start),
    .lane2      (lane2),
    .lane1      (lane1),
    .lane0      (lane0),
    .lane_valid (lane_valid),
    .full       (full),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a tile of loaded elements and a queue of the beats a stream must produce.
  typedef struct packed {
    logic [12:0] l2, l1, l0;
    logic        v, d;
  } beat_t;
  beat_t       q[$];
  beat_t       exp_b = '0;
  beat_t       nb;
  logic [12:0] tile [9];
  int          cnt = 0;
  bit          m_rdy, m_full;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      cnt = 0;
      exp_b = '0;
    end else begin
      m_rdy  = q.size() == 0 && cnt < 9;
      m_full = q.size() == 0 && cnt == 9;
      exp_b  = q.size() != 0 ? q.pop_front() : '0;
      if (m_rdy && wr_valid) begin
        tile[cnt] = wr_data;
        cnt++;
      end
      if (m_full && start) begin
        for (int r = 0; r < 3; r++) begin
          nb = '{l2: tile[3*r], l1: tile[3*r+1], l0: tile[3*r+2], v: 1'b1, d: 1'b0};
          q.push_back(nb);
        end
        nb = '{l2: 13'd0, l1: 13'd0, l0: 13'd0, v: 1'b1, d: 1'b0};
        q.push_back(nb);
        q.push_back(nb);
        nb = '{l2: 13'd0, l1: 13'd0, l0: 13'd0, v: 1'b0, d: 1'b1};
        q.push_back(nb);
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m.lane2", lane2, exp_b.l2);
    chk("m.lane1", lane1, exp_b.l1);
    chk("m.lane0", lane0, exp_b.l0);
    chk("m.lane_valid", lane_valid, exp_b.v);
    chk("m.done", done, exp_b.d);
    chk("m.wr_ready", wr_ready, q.size() == 0 && cnt < 9);
    chk("m.full", full, q.size() == 0 && cnt == 9);
  end

  task automatic beat(input string nm, input logic [12:0] a, b, c, input logic v, d);
    @(negedge clk);
    chk({nm, ".lane2"}, lane2, a);
    chk({nm, ".lane1"}, lane1, b);
    chk({nm, ".lane0"}, lane0, c);
    chk({nm, ".valid"}, lane_valid, v);
    chk({nm, ".done"}, done, d);
  endtask

  task automatic put(input logic [12:0] d, input bit gap);
    int  n = 0;
    bit  acc;
    if (gap) begin
      wr_valid = 1'b0;
      @(negedge clk);
    end
    wr_valid = 1'b1;
    wr_data  = d;
    do begin
      acc = wr_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      errs++;
      $display("FAIL write_timeout: wr_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic load(input logic [12:0] first, input logic [12:0] inc, input bit gap);
    logic [12:0] d = first;
    for (int k = 0; k < 9; k++) begin
      put(d, gap);
      d = d + inc;
    end
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.lane_valid", lane_valid, 0);
    chk("rst.lane2", lane2, 0);
    chk("rst.full", full, 0);
    chk("rst.done", done, 0);
    chk("rst.wr_ready", wr_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    // tile 1..9, continuous writes
    load(13'd1, 13'd1, 1'b0);
    chk("t1.full", full, 1);
    chk("t1.wr_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = 13'd99;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    chk("t1.full_held", full, 1);
    pulse_start();
    beat("t1.r0", 13'd1, 13'd2, 13'd3, 1, 0);
    beat("t1.r1", 13'd4, 13'd5, 13'd6, 1, 0);
    beat("t1.r2", 13'd7, 13'd8, 13'd9, 1, 0);
    beat("t1.f0", 13'd0, 13'd0, 13'd0, 1, 0);
    beat("t1.f1", 13'd0, 13'd0, 13'd0, 1, 0);
    beat("t1.dn", 13'd0, 13'd0, 13'd0, 0, 1);
    chk("t1.wr_ready_after", wr_ready, 1);
    @(negedge clk);
    // toggling writes with start held through the load
    start = 1'b1;
    load(13'd21, 13'd1, 1'b1);
    start = 1'b0;
    chk("t2.full", full, 1);
    repeat (2) @(negedge clk);
    pulse_start();
    beat("t2.r0", 13'd21, 13'd22, 13'd23, 1, 0);
    repeat (6) @(negedge clk);
    // reset during the row-1 beat
    load(13'd31, 13'd1, 1'b0);
    pulse_start();
    beat("t3.r0", 13'd31, 13'd32, 13'd33, 1, 0);
    beat("t3.r1", 13'd34, 13'd35, 13'd36, 1, 0);
    #1 reset = 1'b1;
    #1;
    chk("t3.rst_valid", lane_valid, 0);
    chk("t3.rst_lane1", lane1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t3.wr_ready", wr_ready, 1);
    chk("t3.full", full, 0);
    load(13'd10, 13'd1, 1'b0);
    pulse_start();
    beat("t3b.r0", 13'd10, 13'd11, 13'd12, 1, 0);
    beat("t3b.r1", 13'd13, 13'd14, 13'd15, 1, 0);
    beat("t3b.r2", 13'd16, 13'd17, 13'd18, 1, 0);
    repeat (4) @(negedge clk);
    // start re-asserted mid-stream, then back-to-back negative tile
    load(13'd40, 13'd1, 1'b0);
    pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4.done", done, 1);
    load(13'h1FFF, 13'h1FFF, 1'b0);
    chk("t4.full", full, 1);
    pulse_start();
    beat("t4.r0", 13'h1FFF, 13'h1FFE, 13'h1FFD, 1, 0);
    beat("t4.r1", 13'h1FFC, 13'h1FFB, 13'h1FFA, 1, 0);
    beat("t4.r2", 13'h1FF9, 13'h1FF8, 13'h1FF7, 1, 0);
    beat("t4.f0", 13'd0, 13'd0, 13'd0, 1, 0);
    beat("t4.f1", 13'd0, 13'd0, 13'd0, 1, 0);
    beat("t4.dn", 13'd0, 13'd0, 13'd0, 0, 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
